// File: rtl/proc_pkg.sv
// Shared types, widths and the alignment/range check for the load/store stage.
package proc_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam logic [DATA_W-1:0] END_PC_DEFAULT = 32'd616;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP,
    ST_HALTED
  } state_e;

  // Both strobes at once, a misaligned access, or a word index past the memory all fault.
  function automatic logic access_fault(input logic              rd,
                                        input logic              wr,
                                        input logic [DATA_W-1:0] addr,
                                        input int unsigned       depth);
    logic is_mem;
    is_mem = rd | wr;
    return (rd & wr)
         | (is_mem & (addr[1:0] != 2'b00))
         | (is_mem & ({2'b00, addr[DATA_W-1:2]} >= depth));
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request, data-memory and writeback signals of the load/store stage.
interface mem_access_stage_if;
  import proc_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_read;
  logic              req_write;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [REG_W-1:0]  req_rd;
  logic [DATA_W-1:0] req_pc;
  logic              halt_req;

  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [REG_W-1:0]  resp_rd;
  logic              resp_reg_write;
  logic              resp_fault;

  logic              halted;
  logic [DATA_W-1:0] halt_pc;

  // Surrounding pipeline: execute stage, data memory and writeback.
  modport master (
    output req_valid, req_read, req_write, req_addr, req_wdata, req_rd, req_pc, halt_req,
    output mem_rdata, resp_ready,
    input  req_ready, mem_write, mem_read, mem_addr, mem_wdata,
    input  resp_valid, resp_data, resp_rd, resp_reg_write, resp_fault, halted, halt_pc
  );

  modport slave (
    input  req_valid, req_read, req_write, req_addr, req_wdata, req_rd, req_pc, halt_req,
    input  mem_rdata, resp_ready,
    output req_ready, mem_write, mem_read, mem_addr, mem_wdata,
    output resp_valid, resp_data, resp_rd, resp_reg_write, resp_fault, halted, halt_pc
  );

endinterface

// File: rtl/mem_access_stage_fault_chk.sv
// Combinational alignment/range check and word-index extraction for a request.
module mem_access_fault_chk
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int         IDX_W = $clog2(DEPTH)
) (
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] addr,
  output logic              fault,
  output logic [IDX_W-1:0]  word_idx
);

  assign fault    = access_fault(read, write, addr, DEPTH);
  assign word_idx = addr[IDX_W+1:2];

endmodule

// File: rtl/mem_access_stage.sv
// Load/store stage: accepts one request, drives the data memory for one cycle,
// returns a writeback bundle, and stops for good on end-of-program or halt.
module mem_access_stage
  import proc_pkg::*;
#(
  parameter int unsigned       DEPTH  = 64,
  parameter logic [DATA_W-1:0] END_PC = END_PC_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_stage_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [DATA_W-1:0] halt_pc_q, halt_pc_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              is_write_q, is_write_d;
  logic              reg_write_q, reg_write_d;
  logic              fault_q, fault_d;

  logic              chk_fault;
  logic [IDX_W-1:0]  chk_idx;

  mem_access_fault_chk #(.DEPTH(DEPTH)) u_fault_chk (
    .read     (bus.req_read),
    .write    (bus.req_write),
    .addr     (bus.req_addr),
    .fault    (chk_fault),
    .word_idx (chk_idx)
  );

  always_comb begin
    // NOTE: every variable gets a default up front so no path can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    halt_pc_d   = halt_pc_q;
    rd_d        = rd_q;
    is_write_d  = is_write_q;
    reg_write_d = reg_write_q;
    fault_d     = fault_q;

    unique case (state_q)
      ST_IDLE: begin
        // Halt outranks everything; the halting request itself is never executed.
        if (bus.halt_req || (bus.req_valid && (bus.req_pc > END_PC))) begin
          state_d   = ST_HALTED;
          halt_pc_d = bus.req_valid ? bus.req_pc : '0;
        end else if (bus.req_valid) begin
          rd_d = bus.req_rd;
          if (chk_fault) begin
            state_d     = ST_RESP;
            fault_d     = 1'b1;
            reg_write_d = 1'b0;
            resp_data_d = '0;
          end else if (!(bus.req_read || bus.req_write)) begin
            state_d     = ST_RESP;
            fault_d     = 1'b0;
            reg_write_d = (bus.req_rd != '0);
            resp_data_d = bus.req_wdata;
          end else begin
            state_d     = ST_ACCESS;
            idx_d       = chk_idx;
            wdata_d     = bus.req_wdata;
            is_write_d  = bus.req_write;
            fault_d     = 1'b0;
            reg_write_d = 1'b0;
            resp_data_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (!is_write_q) begin
          resp_data_d = bus.mem_rdata;
          reg_write_d = (rd_q != '0);
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      ST_HALTED: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      halt_pc_q   <= '0;
      rd_q        <= '0;
      is_write_q  <= 1'b0;
      reg_write_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
      halt_pc_q   <= halt_pc_d;
      rd_q        <= rd_d;
      is_write_q  <= is_write_d;
      reg_write_q <= reg_write_d;
      fault_q     <= fault_d;
    end
  end

  // Gating with rst_n keeps req_ready low while reset is held.
  assign bus.req_ready      = rst_n & (state_q == ST_IDLE);
  assign bus.mem_write      = (state_q == ST_ACCESS) &  is_write_q;
  assign bus.mem_read       = (state_q == ST_ACCESS) & ~is_write_q;
  assign bus.mem_addr       = {{(DATA_W-IDX_W){1'b0}}, idx_q};
  assign bus.mem_wdata      = wdata_q;
  assign bus.resp_valid     = (state_q == ST_RESP);
  assign bus.resp_data      = resp_data_q;
  assign bus.resp_rd        = rd_q;
  assign bus.resp_reg_write = reg_write_q;
  assign bus.resp_fault     = fault_q;
  assign bus.halted         = (state_q == ST_HALTED);
  assign bus.halt_pc        = halt_pc_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Load/store stage placed directly upstream of the processor's 64-word data memory. It accepts one execute-stage result at a time over a valid/ready handshake and checks alignment and range. It drives the data memory's write/read strobes, word address and write data, registers the read data, and returns a writeback bundle downstream. It also detects end-of-program and latches the final PC.

Parameters:
DEPTH, 64, data memory depth in 32-bit words; word index width = $clog2(DEPTH)
END_PC, 616, byte address; a request whose PC is greater than this value ends the program

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  execute stage presents a request
req_ready  out  1  stage can accept a request
req_read  in  1  load
req_write  in  1  store
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data, or the ALU result for non-memory ops
req_rd  in  5  destination register
req_pc  in  32  PC of the instruction
halt_req  in  1  external halt request from control
mem_write  out  1  data memory write strobe
mem_read  out  1  data memory read strobe
mem_addr  out  32  word index, zero-extended
mem_wdata  out  32  data memory write data
mem_rdata  in  32  data memory combinational read data
resp_valid  out  1  writeback bundle valid
resp_ready  in  1  writeback accepts the bundle
resp_data  out  32  load data or pass-through value
resp_rd  out  5  destination register
resp_reg_write  out  1  writeback must write resp_rd
resp_fault  out  1  request was faulted and performed no memory access
halted  out  1  program ended
halt_pc  out  32  PC latched at halt

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output is 0, except req_ready, which is 1 once reset is released and the block is in IDLE.
- States: IDLE, ACCESS, RESP, HALTED.
- IDLE: req_ready=1. A request is accepted on the rising edge where req_valid=1. Evaluate in this order:
  - halt_req=1 or req_pc>END_PC: the request is not executed; halt_pc<=req_pc; go to HALTED. If halt_req=1 with req_valid=0, halt_pc<=0.
  - Fault: req_read and req_write both 1, or (read or write) with req_addr[1:0]!=0, or req_addr[31:2]>=DEPTH. Go to RESP with resp_fault=1, resp_reg_write=0, resp_data=0. No memory strobe is ever asserted.
  - Neither read nor write: go to RESP with resp_data=req_wdata and resp_reg_write=(req_rd!=0). Latency is 1 cycle.
  - Read or write: register the word index, wdata, rd and the operation type; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr=index; mem_wdata=registered wdata.
  - mem_write=1 for a store, mem_read=1 for a load. Both are 0 in every other state.
  - Load: resp_data<=mem_rdata at the end of the cycle and resp_reg_write=(rd!=0).
  - Store: resp_reg_write=0, resp_data=0.
  - Go to RESP. Memory-op latency: accept edge to resp_valid = 2 cycles.
- RESP: resp_valid=1. The bundle stays stable until resp_ready=1, then go to IDLE. req_ready=0 in RESP; there is no accept in the same cycle as the response drains.
- HALTED: halted=1; req_ready=0; no strobes and no responses. Only reset leaves this state. halt_pc is held.
- mem_addr/mem_wdata hold their last values outside ACCESS; only the strobes qualify them.
- Reset mid-ACCESS: the strobe drops immediately and asynchronously, and the store is not guaranteed to complete.
- halt_req during ACCESS/RESP: ignored until the next IDLE cycle. Requests to r0 never set resp_reg_write.

Decomposition:
- Shared package (proc_pkg):
  - state enum (IDLE/ACCESS/RESP/HALTED)
  - END_PC default
  - DATA_W=32
  - REG_W=5
  - the fault-check function (align + range)
- One natural sub-module: mem_access_fault_chk, combinational; inputs read, write, addr; outputs fault and word index.
- FSM, registers and handshake stay in mem_access_stage.

Test Plan:
- Store then load: write addr=0x10, wdata=0xDEADBEEF, rd=0 → mem_write=1 for exactly one cycle with mem_addr=4; then read addr=0x10, rd=3 → resp_data=0xDEADBEEF, resp_rd=3, resp_reg_write=1 two cycles after accept.
- Pass-through: no read/write, wdata=0x1234, rd=7 → resp_valid one cycle after accept, resp_data=0x1234, no strobes.
- Faults: read addr=0x102 (misaligned), read addr=0x100 (index 64) and read+write together → resp_fault=1, resp_reg_write=0, mem_read/mem_write never asserted.
- Backpressure: resp_ready held 0 for 5 cycles during a load → bundle stable; req_ready=0 throughout; accepted on the first resp_ready=1.
- End of program: request with req_pc=620 → halted=1, halt_pc=620, no strobe; later req_valid ignored; rst_n pulse returns the block to IDLE with all outputs 0.
- Async reset asserted mid-ACCESS of a store → mem_write drops in the same cycle; after release the block is in IDLE with req_ready=1.
